piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
Parallel-in serial-out transmitter, the sending end of the team's serial bit link; its single-bit output feeds the `sipo` receiver's `si` input.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per clock with a per-bit valid strobe and an end-of-word pulse.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  word valid; the word is accepted on a rising edge where load && ready.
- din  input  WIDTH  parallel word; sampled only on the accept edge.
- ready  output  1  transmitter can accept a word this cycle (combinational from state).
- so  output  1  serial data out (registered).
- so_valid  output  1  so carries a valid bit this cycle (registered).
- done  output  1  one-cycle pulse coinciding with the last bit of a frame (registered).

Behaviour:
- Reset (rst=1 at a clock edge):
  - so=0, so_valid=0, done=0, ready=1.
  - State IDLE; shift register and bit counter cleared.
  - Reset takes priority over every other input.
- States (enum): IDLE, SHIFT, and PARITY (PARITY only with the optional feature).
- IDLE:
  - ready=1, so=0, so_valid=0.
  - On load=1, go to SHIFT on the same edge: shift register <= din, first bit placed on so, so_valid<=1, counter<=0.
- SHIFT:
  - Each edge presents the next bit and increments the counter (width $clog2(WIDTH)).
  - so_valid stays high for exactly WIDTH consecutive cycles, starting the cycle after the accept edge.
- Last data bit (counter == WIDTH-1, no parity):
  - done=1 this cycle; ready=1 this cycle.
  - If load=1 here, the next word is accepted: the first bit of the new word follows immediately, so_valid stays high, and there is zero gap.
  - Otherwise return to IDLE; so_valid=0 and so=0 next cycle.
- load while ready=0: ignored, no effect; din changes mid-frame have no effect.
- rst mid-frame: the frame is aborted on that edge; no done pulse; the partial word is discarded.
- Latency: accept edge to first valid bit = 1 cycle; frame length = WIDTH cycles (WIDTH+1 with parity).
- No over-run or under-run states; holding load=1 continuously produces a continuous bit stream.

Optional Feature:
Macro: PISO_TX_PARITY_EN.
- Defined:
  - After the last data bit, the PARITY state drives so = XOR of all WIDTH data bits (even parity), with so_valid=1 for one more cycle.
  - done and ready move to the parity cycle; back-to-back accept happens on the parity cycle.
  - Frame length = WIDTH+1.
- Undefined:
  - No PARITY state; frame length = WIDTH; done and ready fall on the last data bit.

Decomposition:
- Package piso_pkg holds:
  - state enum type (IDLE, SHIFT, PARITY);
  - default WIDTH constant;
  - counter width function/constant ($clog2(WIDTH)).
- One natural sub-module, piso_bit_counter: loadable modulo-WIDTH counter with clear and a terminal-count flag.
- Shift register and FSM stay in piso_tx.

Test Plan:
- WIDTH=4, MSB_FIRST=1, rst for 2 cycles, then load=1 with din=4'b1001 for one cycle -> so=1,0,0,1 on cycles 1-4 after accept; so_valid high for exactly those 4 cycles; done=1 only on cycle 4; ready=0 on cycles 1-3 and 1 on cycle 4.
- Back-to-back: din=4'b1001, then load held with din=4'b0110 on the done cycle -> 8 contiguous valid bits 1,0,0,1,0,1,1,0; two done pulses 4 cycles apart.
- Load while busy: pulse load with din=4'b1111 on cycle 2 of a 4'b1001 frame -> stream unchanged (1,0,0,1); no extra frame follows.
- Reset mid-frame: assert rst on cycle 2 of a 4'b1001 frame -> next cycle so=0, so_valid=0, done=0, ready=1; a new load of 4'b0011 then transmits cleanly as 0,0,1,1.
- Loopback: so into sipo.si, same clk/rst, send 4'b1011 -> sipo.q == 4'b1011 on the cycle after the 4th bit.
- PISO_TX_PARITY_EN defined, din=4'b1011 -> so=1,0,1,1,1 (parity=1); so_valid high 5 cycles; done on the 5th cycle; din=4'b1001 gives parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_tx serial transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

  localparam int PISO_WIDTH_DEF = 4;

  // Bit-counter width; never below 1 so WIDTH=2 still gets a real register.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable modulo-WIDTH bit counter with clear and terminal-count flag.
// Priority: rst, clr, ld, en.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic [CW-1:0] ld_val_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one bit per clock, done on the frame's last bit.
// Optional even-parity trailer bit when PISO_TX_PARITY_EN is defined.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  piso_state_e      state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             so_q;
  logic             so_valid_q;
  logic             done_q;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             last_bit;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

`ifdef PISO_TX_PARITY_EN
  logic par_q;
  assign last_bit = (state_q == PARITY);
`else
  assign last_bit = (state_q == SHIFT) && tc;
`endif

  // The final bit cycle of a frame is also an accept slot, giving zero-gap streaming.
  assign ready   = (state_q == IDLE) || last_bit;
  assign accept  = load && ready;
  assign shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (last_bit && !accept),
    .ld_i     (accept),
    .ld_val_i ('0),
    .en_i     ((state_q == SHIFT) && !tc),
    .cnt_o    (cnt),
    .tc_o     (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q    <= SHIFT;
        shift_q    <= din;
        so_q       <= first_bit(din);
        so_valid_q <= 1'b1;
`ifdef PISO_TX_PARITY_EN
        par_q      <= ^din;
`endif
      end else begin
        case (state_q)
          SHIFT: begin
            if (tc) begin
`ifdef PISO_TX_PARITY_EN
              state_q    <= PARITY;
              so_q       <= par_q;
              so_valid_q <= 1'b1;
              done_q     <= 1'b1;
`else
              state_q    <= IDLE;
              so_q       <= 1'b0;
              so_valid_q <= 1'b0;
`endif
            end else begin
              shift_q <= shift_d;
              so_q    <= first_bit(shift_d);
`ifndef PISO_TX_PARITY_EN
              // Raise done so it lands on the cycle that carries the last data bit.
              done_q  <= (cnt == CW'(WIDTH - 2));
`endif
            end
          end
          default: begin
            state_q    <= IDLE;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=4, MSB first).
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic       ready;
  logic       so;
  logic       so_valid;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] rx_q;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .ready    (ready),
    .so       (so),
    .so_valid (so_valid),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference deserializer standing in for the sipo receiver.
  always @(posedge clk) begin
    if (rst) rx_q <= 4'b0000;
    else if (so_valid) rx_q <= {rx_q[2:0], so};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; din = 4'b0000;
    tick();
    tick();
    n_cmp++; if (so !== 1'b0)       begin n_err++; $display("FAIL reset_so: got %b want 0", so); end
    n_cmp++; if (so_valid !== 1'b0) begin n_err++; $display("FAIL reset_so_valid: got %b want 0", so_valid); end
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (ready !== 1'b1)    begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
    tick();
  endtask

`ifndef PISO_TX_PARITY_EN
  task automatic test_single_frame();
    logic [3:0] w;
    w = 4'b1001;
    load = 1'b1; din = w;
    tick();
    load = 1'b0; din = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (so !== w[3-i])         begin n_err++; $display("FAIL single_so[%0d]: got %b want %b", i, so, w[3-i]); end
      n_cmp++; if (so_valid !== 1'b1)     begin n_err++; $display("FAIL single_vld[%0d]: got %b want 1", i, so_valid); end
      n_cmp++; if (done !== (i == 3))     begin n_err++; $display("FAIL single_done[%0d]: got %b want %b", i, done, (i == 3)); end
      n_cmp++; if (ready !== (i == 3))    begin n_err++; $display("FAIL single_ready[%0d]: got %b want %b", i, ready, (i == 3)); end
      tick();
    end
    n_cmp++; if (so_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_vld: got %b want 0", so_valid); end
    n_cmp++; if (so !== 1'b0)       begin n_err++; $display("FAIL single_idle_so: got %b want 0", so); end
    n_cmp++; if (ready !== 1'b1)    begin n_err++; $display("FAIL single_idle_ready: got %b want 1", ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream;
    stream = 8'b1001_0110;
    load = 1'b1; din = 4'b1001;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin load = 1'b1; din = 4'b0110; end
      n_cmp++; if (so !== stream[7-i])           begin n_err++; $display("FAIL b2b_so[%0d]: got %b want %b", i, so, stream[7-i]); end
      n_cmp++; if (so_valid !== 1'b1)            begin n_err++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, so_valid); end
      n_cmp++; if (done !== (i == 3 || i == 7))  begin n_err++; $display("FAIL b2b_done[%0d]: got %b want %b", i, done, (i == 3 || i == 7)); end
      tick();
      load = 1'b0;
    end
    n_cmp++; if (so_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_vld: got %b want 0", so_valid); end
  endtask

  task automatic test_load_while_busy();
    logic [3:0] w;
    w = 4'b1001;
    load = 1'b1; din = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin load = 1'b1; din = 4'b1111; end
      n_cmp++; if (so !== w[3-i])     begin n_err++; $display("FAIL busy_so[%0d]: got %b want %b", i, so, w[3-i]); end
      n_cmp++; if (so_valid !== 1'b1) begin n_err++; $display("FAIL busy_vld[%0d]: got %b want 1", i, so_valid); end
      tick();
      load = 1'b0; din = 4'b0000;
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (so_valid !== 1'b0) begin n_err++; $display("FAIL busy_extra_vld[%0d]: got %b want 0", i, so_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] w;
    load = 1'b1; din = 4'b1001;
    tick();
    load = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (so !== 1'b0)       begin n_err++; $display("FAIL midrst_so: got %b want 0", so); end
    n_cmp++; if (so_valid !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b want 0", so_valid); end
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
    n_cmp++; if (ready !== 1'b1)    begin n_err++; $display("FAIL midrst_ready: got %b want 1", ready); end
    w = 4'b0011;
    load = 1'b1; din = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (so !== w[3-i])     begin n_err++; $display("FAIL midrst_new_so[%0d]: got %b want %b", i, so, w[3-i]); end
      n_cmp++; if (done !== (i == 3)) begin n_err++; $display("FAIL midrst_new_done[%0d]: got %b want %b", i, done, (i == 3)); end
      tick();
    end
  endtask

  task automatic test_loopback();
    load = 1'b1; din = 4'b1011;
    tick();
    load = 1'b0; din = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (rx_q !== 4'b1011) begin n_err++; $display("FAIL loopback_word: got %b want 1011", rx_q); end
  endtask

  task automatic test_lsb_timing_gap();
    // Idle cycle between frames must not emit spurious valid bits.
    tick();
    n_cmp++; if (so_valid !== 1'b0 || ready !== 1'b1) begin
      n_err++; $display("FAIL idle_gap: got vld=%b rdy=%b want vld=0 rdy=1", so_valid, ready);
    end
  endtask
`else
  task automatic test_parity();
    logic [4:0] exp_a;
    logic [4:0] exp_b;
    exp_a = 5'b10111;
    exp_b = 5'b10010;
    load = 1'b1; din = 4'b1011;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (so !== exp_a[4-i])   begin n_err++; $display("FAIL par_a_so[%0d]: got %b want %b", i, so, exp_a[4-i]); end
      n_cmp++; if (so_valid !== 1'b1)   begin n_err++; $display("FAIL par_a_vld[%0d]: got %b want 1", i, so_valid); end
      n_cmp++; if (done !== (i == 4))   begin n_err++; $display("FAIL par_a_done[%0d]: got %b want %b", i, done, (i == 4)); end
      n_cmp++; if (ready !== (i == 4))  begin n_err++; $display("FAIL par_a_ready[%0d]: got %b want %b", i, ready, (i == 4)); end
      if (i == 4) begin load = 1'b1; din = 4'b1001; end
      tick();
      load = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (so !== exp_b[4-i]) begin n_err++; $display("FAIL par_b_so[%0d]: got %b want %b", i, so, exp_b[4-i]); end
      n_cmp++; if (so_valid !== 1'b1) begin n_err++; $display("FAIL par_b_vld[%0d]: got %b want 1", i, so_valid); end
      tick();
    end
    n_cmp++; if (so_valid !== 1'b0) begin n_err++; $display("FAIL par_idle_vld: got %b want 0", so_valid); end
  endtask
`endif

  initial begin
    rst = 1'b1; load = 1'b0; din = 4'b0000;
    test_reset();
`ifndef PISO_TX_PARITY_EN
    test_single_frame();
    test_lsb_timing_gap();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid_frame();
    test_loopback();
`else
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
